// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N requesters, granted per burst.
// Optional FIFO_ARB_STALL_CNT_EN adds o_StallCount, a saturating count of full-blocked beats.
module fifo_write_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [N-1:0]       i_Req,
    input  logic [N*WIDTH-1:0] i_ReqData,
    input  logic [N-1:0]       i_Last,
    output logic [N-1:0]       o_Grant,
    output logic [N-1:0]       o_Ack,
    output logic               o_WrEn,
    output logic [WIDTH-1:0]   o_WrData,
    input  logic               i_Full,
    output logic               o_Busy
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    output logic [15:0]        o_StallCount
`endif
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    logic [PW-1:0]   g_idx;
    logic            req_g;
    logic            last_g;
    logic            wr_en;
    logic            burst_hit;
    logic            rel_grant;
    logic [N-1:0]    pick_idle;
    logic [N-1:0]    pick_rel;

    // First set bit strictly after ptr, wrapping, so ptr itself is searched last.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input logic [PW-1:0] ptr);
        logic [N-1:0]  pick;
        logic          found;
        logic [PW-1:0] idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        g_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_q[k]) g_idx = PW'(k);
        end
    end

    assign req_g     = |(i_Req & grant_q);
    assign last_g    = |(i_Last & grant_q);
    assign wr_en     = (state_q == S_GRANT) && req_g && !i_Full;
    assign burst_hit = (9'(cnt_q) + 9'd1) == 9'(MAX_BURST);
    // A dropped request releases even while full; otherwise release needs an accepted beat.
    assign rel_grant = !req_g || (wr_en && (last_g || burst_hit));
    assign pick_idle = rr_pick(i_Req, ptr_q);
    assign pick_rel  = rr_pick(i_Req, g_idx);

    assign o_WrEn   = wr_en;
    assign o_WrData = i_ReqData[g_idx*WIDTH +: WIDTH];
    assign o_Ack    = wr_en ? grant_q : '0;
    assign o_Grant  = grant_q;
    assign o_Busy   = (state_q == S_GRANT);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (|i_Req) begin
                    grant_d = pick_idle;
                    cnt_d   = '0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (rel_grant) begin
                    ptr_d = g_idx;
                    cnt_d = '0;
                    if (|i_Req) begin
                        grant_d = pick_rel;
                    end else begin
                        grant_d = '0;
                        state_d = S_IDLE;
                    end
                end else if (wr_en) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= PW'(N - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            stall_q <= '0;
        end else if ((state_q == S_GRANT) && req_g && i_Full && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign o_StallCount = stall_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: vector table, directed burst scenarios, random traffic vs a model.
// Set FIFO_ARB_STALL_CNT_EN to also check o_StallCount.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk   = 1'b0;
    logic           rst   = 1'b1;
    logic [N-1:0]   req   = '0;
    logic [N-1:0]   last  = '0;
    logic [N*W-1:0] rdata = '0;
    logic           full  = 1'b0;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic           wren;
    logic [W-1:0]   wdata;
    logic           busy;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0]    stall;
`endif

    always #5 clk = ~clk;

    fifo_write_arbiter #(.N(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_Req(req),
        .i_ReqData(rdata),
        .i_Last(last),
        .o_Grant(grant),
        .o_Ack(ack),
        .o_WrEn(wren),
        .o_WrData(wdata),
        .i_Full(full),
        .o_Busy(busy)
`ifdef FIFO_ARB_STALL_CNT_EN
        ,
        .o_StallCount(stall)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_g;
    int m_ptr;
    int m_cnt;
    int m_stall;

    function automatic int rr_next(input int from, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        logic [N-1:0] eg;
        logic [N-1:0] ea;
        logic         ew;
        logic         eb;
        eg = '0; ea = '0; ew = 1'b0; eb = 1'b0;
        if (!rst && m_g >= 0) begin
            eg[m_g] = 1'b1;
            eb      = 1'b1;
            ew      = req[m_g] && !full;
            if (ew) ea[m_g] = 1'b1;
        end
        chk("grant", 32'(grant), 32'(eg));
        chk("wren", 32'(wren), 32'(ew));
        chk("ack", 32'(ack), 32'(ea));
        chk("busy", 32'(busy), 32'(eb));
        if (ew) chk("wrdata", 32'(wdata), 32'(rdata[m_g*W +: W]));
        chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        chk("wren_while_full", 32'(wren & full), 32'd0);
`ifdef FIFO_ARB_STALL_CNT_EN
        chk("stall_count", 32'(stall), rst ? 32'd0 : 32'(m_stall));
`endif
    endtask

    task automatic model_advance();
        logic acc;
        logic rel;
        if (rst) begin
            m_g = -1; m_ptr = N - 1; m_cnt = 0; m_stall = 0;
        end else if (m_g < 0) begin
            if (req != '0) begin
                m_g   = rr_next(m_ptr, req);
                m_cnt = 0;
            end
        end else begin
            acc = req[m_g] && !full;
            if (req[m_g] && full && m_stall < 65535) m_stall++;
            if (acc) m_cnt++;
            rel = !req[m_g] || (acc && (last[m_g] || m_cnt == MB));
            if (rel) begin
                m_ptr = m_g;
                m_cnt = 0;
                m_g   = (req != '0) ? rr_next(m_g, req) : -1;
            end
        end
    endtask

    // ---------------- requester sources and scoreboard ----------------
    logic [W-1:0] src_data [N][64];
    logic         src_last [N][64];
    int           src_head [N];
    int           src_tail [N];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    function automatic int src_cnt(input int k);
        return src_tail[k] - src_head[k];
    endfunction

    task automatic push_word(input int k, input logic [W-1:0] d, input logic l);
        src_data[k][src_tail[k] % 64] = d;
        src_last[k][src_tail[k] % 64] = l;
        src_tail[k]++;
    endtask

    task automatic clear_src();
        for (int k = 0; k < N; k++) begin
            src_head[k] = 0;
            src_tail[k] = 0;
        end
    endtask

    task automatic drive_from_src();
        for (int k = 0; k < N; k++) begin
            if (src_cnt(k) > 0) begin
                req[k]          = 1'b1;
                last[k]         = src_last[k][src_head[k] % 64];
                rdata[k*W +: W] = src_data[k][src_head[k] % 64];
            end else begin
                req[k]  = 1'b0;
                last[k] = 1'b0;
            end
        end
    endtask

    // Called at posedge+1: drive, check at negedge, then advance to the next posedge+1.
    task automatic cycle(input logic r, input logic f);
        rst  = r;
        full = f;
        drive_from_src();
        @(negedge clk);
        check_outputs();
        if (!r) begin
            if (wren) got_q.push_back(wdata);
            for (int k = 0; k < N; k++) begin
                if (ack[k] && src_cnt(k) > 0) begin
                    chk("src_order", 32'(wdata), 32'(src_data[k][src_head[k] % 64]));
                    src_head[k]++;
                end
            end
        end
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_src();
        cycle(1'b1, 1'b0);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic run_drain(input int max_cycles);
        int n;
        logic pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < max_cycles) begin
            cycle(1'b0, 1'b0);
            n++;
            pending = busy;
            for (int k = 0; k < N; k++) if (src_cnt(k) > 0) pending = 1'b1;
        end
        if (pending) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_sb(input string name);
        chk({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk({name, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] last;
        logic         full;
        logic [N-1:0] e_grant;
        logic         e_wren;
        logic [N-1:0] e_ack;
        logic         e_busy;
        logic [W-1:0] e_wdata;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        tbl[1]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        tbl[2]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA0};
        tbl[3]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA0};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'h00};
        tbl[5]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        tbl[6]  = '{4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'hB1};
        tbl[7]  = '{4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hC2};
        tbl[8]  = '{4'b1111, 4'b1111, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'hD3};
        tbl[9]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'h00};
        tbl[10] = '{4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA0};
        tbl[11] = '{4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h00};
        tbl[12] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};

        // Reset state
        rst = 1'b1;
        @(negedge clk);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_wren", 32'(wren), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        rdata = 32'hD3C2B1A0;
        for (int i = 0; i < 13; i++) begin
            req  = tbl[i].req;
            last = tbl[i].last;
            full = tbl[i].full;
            @(negedge clk);
            chk("tbl_grant", 32'(grant), 32'(tbl[i].e_grant));
            chk("tbl_wren", 32'(wren), 32'(tbl[i].e_wren));
            chk("tbl_ack", 32'(ack), 32'(tbl[i].e_ack));
            chk("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
            if (tbl[i].e_wren) chk("tbl_wdata", 32'(wdata), 32'(tbl[i].e_wdata));
            @(posedge clk);
            #1;
        end

        // Single requester, three-beat burst
        do_reset();
        push_word(0, 8'hA1, 1'b0);
        push_word(0, 8'hA2, 1'b0);
        push_word(0, 8'hA3, 1'b1);
        exp_q = '{8'hA1, 8'hA2, 8'hA3};
        run_drain(40);
        check_sb("single");

        // Forced rotation at MAX_BURST
        do_reset();
        for (int i = 0; i < 10; i++) push_word(1, 8'(8'h10 + i), 1'b0);
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push_word(2, 8'(8'h20 + i), i == 2);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22,
                  8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
        run_drain(60);
        check_sb("max_burst");

        // Full backpressure for five cycles mid-burst
        do_reset();
        for (int i = 0; i < 5; i++) push_word(0, 8'(8'h30 + i), i == 4);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b1);
        run_drain(40);
        exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
        check_sb("full");
`ifdef FIFO_ARB_STALL_CNT_EN
        chk("stall_after_full", 32'(stall), 32'd5);
`endif

        // Granted requester drops while blocked by full
        do_reset();
        push_word(0, 8'h40, 1'b0);
        push_word(0, 8'h41, 1'b0);
        push_word(0, 8'h42, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        push_word(3, 8'h50, 1'b1);
        cycle(1'b0, 1'b1);
        src_head[0] = src_tail[0];
        cycle(1'b0, 1'b1);
        chk("drop_grant", 32'(grant), 32'(4'b1000));
        run_drain(40);
        exp_q = '{8'h40, 8'h50};
        check_sb("drop");

        // Reset during beat 2 of 4
        do_reset();
        for (int i = 0; i < 4; i++) push_word(0, 8'(8'h60 + i), i == 3);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        rst = 1'b0;
        clear_src();
        push_word(2, 8'h70, 1'b1);
        push_word(0, 8'h71, 1'b1);
        cycle(1'b0, 1'b0);
        chk("restart_grant", 32'(grant), 32'(4'b0001));
        run_drain(40);
        exp_q = '{8'h60, 8'h71, 8'h70};
        check_sb("reset_mid");

        // Random traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic r;
            logic f;
            for (int k = 0; k < N; k++) begin
                if (src_cnt(k) == 0 && $urandom_range(0, 5) == 0) begin
                    int  len;
                    logic nolast;
                    len    = $urandom_range(1, 6);
                    nolast = ($urandom_range(0, 3) == 0);
                    for (int j = 0; j < len; j++) begin
                        push_word(k, 8'($urandom_range(0, 255)), (j == len - 1) && !nolast);
                    end
                end
            end
            f = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 299) == 0);
            cycle(r, f);
            if (r) begin
                rst = 1'b0;
                clear_src();
            end
        end
        run_drain(200);
        got_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
